// File: rtl/fft_pkg.sv
// Shared types and constants for the 64-point FFT sequencer.
package fft_pkg;

   localparam int unsigned N_LOG2 = 6;
   localparam int unsigned N      = 64;

   typedef logic [N_LOG2-1:0] addr_t;
   typedef logic [N_LOG2-2:0] tw_idx_t;
   typedef logic [N_LOG2-2:0] bf_idx_t;
   typedef logic [2:0]        stage_t;

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StRun,
      StDrain,
      StUnload
   } state_e;

   // One writeback pipeline slot: strobe plus both butterfly addresses.
   typedef struct packed {
      logic  en;
      addr_t a;
      addr_t b;
   } wb_t;

   function automatic addr_t bit_reverse(addr_t v);
      addr_t r;
      for (int i = 0; i < N_LOG2; i++) begin
         r[i] = v[N_LOG2-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_bf_addr.sv
// Radix-2 DIT butterfly address generator: (stage, k) -> operand pair and twiddle.
module fft_bf_addr
   import fft_pkg::*;
(
   input  stage_t  stage_i,
   input  bf_idx_t k_i,
   output addr_t   addr_a_o,
   output addr_t   addr_b_o,
   output tw_idx_t tw_idx_o
);

   addr_t span;
   addr_t pos;
   addr_t grp;
   addr_t base;

   // span = 2^stage; k splits into group (upper bits) and position within the group.
   always_comb begin
      span     = addr_t'(1) << stage_i;
      pos      = {1'b0, k_i} & (span - addr_t'(1));
      grp      = {1'b0, k_i} >> stage_i;
      base     = (grp << stage_i) << 1;
      addr_a_o = base | pos;
      addr_b_o = (base | pos) + span;
      tw_idx_o = tw_idx_t'(pos << (3'd5 - stage_i));
   end

endmodule

// File: rtl/fft_sequencer.sv
// Control sequencer for an in-place 64-point FFT: load, 6 butterfly stages, unload.
module fft_sequencer
   import fft_pkg::*;
#(
   parameter int unsigned BF_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ld_we,
   output logic [N_LOG2-1:0] ld_addr,
   output logic              bf_en,
   output logic [N_LOG2-1:0] bf_addr_a,
   output logic [N_LOG2-1:0] bf_addr_b,
   output logic [N_LOG2-2:0] tw_idx,
   output logic [2:0]        stage,
   output logic              wb_en,
   output logic [N_LOG2-1:0] wb_addr_a,
   output logic [N_LOG2-1:0] wb_addr_b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N_LOG2-1:0] rd_addr
);

   state_e  state_q;
   addr_t   n_q;
   bf_idx_t k_q;
   stage_t  stg_q;
   logic [2:0] d_q;

   logic    busy_q, done_q, in_ready_q, ld_we_q, bf_en_q, out_valid_q;
   addr_t   ld_addr_q, bf_addr_a_q, bf_addr_b_q, rd_addr_q;
   tw_idx_t tw_idx_q;
   stage_t  stage_q;

   addr_t   gen_a, gen_b;
   tw_idx_t gen_tw;

   wb_t wb_pipe_q [BF_LAT];

   fft_bf_addr u_bf_addr (
      .stage_i  (stg_q),
      .k_i      (k_q),
      .addr_a_o (gen_a),
      .addr_b_o (gen_b),
      .tw_idx_o (gen_tw)
   );

   // Main FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         n_q         <= '0;
         k_q         <= '0;
         stg_q       <= '0;
         d_q         <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         ld_we_q     <= 1'b0;
         ld_addr_q   <= '0;
         bf_en_q     <= 1'b0;
         bf_addr_a_q <= '0;
         bf_addr_b_q <= '0;
         tw_idx_q    <= '0;
         stage_q     <= '0;
         out_valid_q <= 1'b0;
         rd_addr_q   <= '0;
      end else begin
         done_q  <= 1'b0;
         ld_we_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StLoad;
                  busy_q     <= 1'b1;
                  in_ready_q <= 1'b1;
                  n_q        <= '0;
               end
            end
            StLoad: begin
               // A stalled cycle leaves ld_addr holding the last written address.
               if (in_valid) begin
                  ld_we_q   <= 1'b1;
                  ld_addr_q <= bit_reverse(n_q);
                  n_q       <= n_q + addr_t'(1);
                  if (n_q == addr_t'(N - 1)) begin
                     state_q    <= StRun;
                     in_ready_q <= 1'b0;
                     stg_q      <= '0;
                     k_q        <= '0;
                  end
               end
            end
            StRun: begin
               ld_addr_q   <= '0;
               bf_en_q     <= 1'b1;
               bf_addr_a_q <= gen_a;
               bf_addr_b_q <= gen_b;
               tw_idx_q    <= gen_tw;
               stage_q     <= stg_q;
               k_q         <= k_q + bf_idx_t'(1);
               if (k_q == bf_idx_t'(N / 2 - 1)) begin
                  state_q <= StDrain;
                  d_q     <= '0;
               end
            end
            StDrain: begin
               // Idle issue slots let the last writebacks of this stage land.
               bf_en_q     <= 1'b0;
               bf_addr_a_q <= '0;
               bf_addr_b_q <= '0;
               tw_idx_q    <= '0;
               if (d_q == 3'(BF_LAT - 1)) begin
                  d_q <= '0;
                  if (stg_q == stage_t'(N_LOG2 - 1)) begin
                     state_q     <= StUnload;
                     stg_q       <= '0;
                     stage_q     <= '0;
                     out_valid_q <= 1'b1;
                     rd_addr_q   <= '0;
                  end else begin
                     state_q <= StRun;
                     stg_q   <= stg_q + stage_t'(1);
                     k_q     <= '0;
                  end
               end else begin
                  d_q <= d_q + 3'd1;
               end
            end
            StUnload: begin
               if (out_ready) begin
                  if (rd_addr_q == addr_t'(N - 1)) begin
                     state_q     <= StIdle;
                     done_q      <= 1'b1;
                     busy_q      <= 1'b0;
                     out_valid_q <= 1'b0;
                     rd_addr_q   <= '0;
                  end else begin
                     rd_addr_q <= rd_addr_q + addr_t'(1);
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Writeback shift pipeline: issue strobe/addresses delayed by BF_LAT cycles.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < BF_LAT; i++) begin
            wb_pipe_q[i] <= '0;
         end
      end else begin
         wb_pipe_q[0] <= '{en: bf_en_q, a: bf_addr_a_q, b: bf_addr_b_q};
         for (int unsigned i = 1; i < BF_LAT; i++) begin
            wb_pipe_q[i] <= wb_pipe_q[i-1];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign in_ready  = in_ready_q;
   assign ld_we     = ld_we_q;
   assign ld_addr   = ld_addr_q;
   assign bf_en     = bf_en_q;
   assign bf_addr_a = bf_addr_a_q;
   assign bf_addr_b = bf_addr_b_q;
   assign tw_idx    = tw_idx_q;
   assign stage     = stage_q;
   assign wb_en     = wb_pipe_q[BF_LAT-1].en;
   assign wb_addr_a = wb_pipe_q[BF_LAT-1].a;
   assign wb_addr_b = wb_pipe_q[BF_LAT-1].b;
   assign out_valid = out_valid_q;
   assign rd_addr   = rd_addr_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Self-checking bench for fft_sequencer: scoreboard queues plus an addressing vector table.
module tb_fft_sequencer;

   localparam int BF_LAT    = 2;
   localparam int TOTAL_CYC = 1 + 64 + 6 * (32 + BF_LAT) + 64;

   logic       clk, rst, start, in_valid, out_ready;
   logic       busy, done, in_ready, ld_we, bf_en, wb_en, out_valid;
   logic [5:0] ld_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, rd_addr;
   logic [4:0] tw_idx;
   logic [2:0] stage;

   int n_checks = 0;
   int n_pass   = 0;
   bit rand_ready = 0;

   logic [5:0]  ld_exp [$];
   logic [19:0] bf_exp [$];
   logic [5:0]  rd_exp [$];
   logic [16:0] issued [192];

   // Monitor state
   int          ld_cnt, bf_idx, wb_cnt, gap, hist_n;
   bit          in_run, hold_pending, exp_done;
   logic [5:0]  held;
   logic [12:0] hist [BF_LAT];

   typedef struct {
      int          stg;
      int          k;
      logic [16:0] exp;
   } vec_t;
   vec_t tbl [7];

   fft_sequencer #(.BF_LAT(BF_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .ld_we     (ld_we),
      .ld_addr   (ld_addr),
      .bf_en     (bf_en),
      .bf_addr_a (bf_addr_a),
      .bf_addr_b (bf_addr_b),
      .tw_idx    (tw_idx),
      .stage     (stage),
      .wb_en     (wb_en),
      .wb_addr_a (wb_addr_a),
      .wb_addr_b (wb_addr_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .rd_addr   (rd_addr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({busy, done, in_ready, ld_we, ld_addr, bf_en, bf_addr_a, bf_addr_b, tw_idx,
                  stage, wb_en, wb_addr_a, wb_addr_b, out_valid, rd_addr});
   endfunction

   function automatic logic [5:0] bitrev6(input int n);
      logic [5:0] v, r;
      v = 6'(n);
      for (int i = 0; i < 6; i++) r[i] = v[5-i];
      return r;
   endfunction

   task automatic push_expectations();
      int span, pos, grp, a;
      for (int n = 0; n < 64; n++) ld_exp.push_back(bitrev6(n));
      for (int s = 0; s < 6; s++) begin
         span = 1 << s;
         for (int k = 0; k < 32; k++) begin
            pos = k % span;
            grp = k / span;
            a   = grp * 2 * span + pos;
            bf_exp.push_back({3'(s), 6'(a), 6'(a + span), 5'(pos << (5 - s))});
         end
      end
      for (int m = 0; m < 64; m++) rd_exp.push_back(6'(m));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
   endtask

   task automatic run_transform(input int stall_at, input bit poke, output int cycles);
      bit         stalled, poked;
      logic [5:0] saved;
      stalled = 0;
      poked   = 0;
      cycles  = 0;
      push_expectations();
      start    = 1'b1;
      in_valid = 1'b1;
      while (1) begin
         tick();
         cycles++;
         start = 1'b0;
         if (done) break;
         if (cycles >= 3000) begin
            check("transform_timeout", done, 1);
            break;
         end
         if (!stalled && stall_at >= 0 && ld_cnt >= stall_at) begin
            stalled  = 1;
            saved    = ld_addr;
            in_valid = 1'b0;
            repeat (3) begin
               tick();
               cycles++;
               check("stall_no_we", ld_we, 0);
               check("stall_addr_hold", ld_addr, saved);
            end
            in_valid = 1'b1;
         end
         if (poke && !poked && bf_en && stage == 3'd2) begin
            poked = 1;
            start = 1'b1;
            tick();
            cycles++;
            start = 1'b0;
            check("start_ignored_in_run", {busy, in_ready}, 2'b10);
         end
      end
      in_valid = 1'b0;
      check("ld_queue_drained", ld_exp.size(), 0);
      check("bf_queue_drained", bf_exp.size(), 0);
      check("rd_queue_drained", rd_exp.size(), 0);
   endtask

   // Sample outputs mid-cycle and score them against the expectation queues.
   always @(negedge clk) begin
      if (!rst) begin
         ld_cnt = 0; bf_idx = 0; wb_cnt = 0; gap = 0; hist_n = 0;
         in_run = 0; hold_pending = 0; exp_done = 0;
         for (int i = 0; i < BF_LAT; i++) hist[i] = '0;
      end else begin
         if (exp_done) begin
            check("done_pulse", {done, busy}, 2'b10);
            exp_done = 0;
         end else if (done) begin
            check("done_spurious", done, 0);
         end
         if (!busy) begin
            ld_cnt = 0; bf_idx = 0; wb_cnt = 0; gap = 0;
            in_run = 0; hold_pending = 0;
         end
         if (ld_we) begin
            check("ld_expected", ld_exp.size() != 0, 1);
            if (ld_exp.size() != 0) check("ld_addr", ld_addr, ld_exp.pop_front());
            ld_cnt++;
         end
         if (hist_n >= BF_LAT && (wb_en || hist[BF_LAT-1][12]))
            check("wb_delay", {wb_en, wb_addr_a, wb_addr_b}, hist[BF_LAT-1]);
         for (int i = BF_LAT - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = {bf_en, bf_addr_a, bf_addr_b};
         if (hist_n < BF_LAT) hist_n++;
         if (wb_en) wb_cnt++;
         if (bf_en) begin
            if (in_run && gap != 0) begin
               check("drain_gap", gap, BF_LAT);
               check("prior_wb_done", wb_cnt, 32 * stage);
            end
            gap    = 0;
            in_run = 1;
            check("bf_expected", bf_exp.size() != 0, 1);
            if (bf_exp.size() != 0)
               check("bf_issue", {stage, bf_addr_a, bf_addr_b, tw_idx}, bf_exp.pop_front());
            if (bf_idx < 192) issued[bf_idx] = {bf_addr_a, bf_addr_b, tw_idx};
            bf_idx++;
         end else if (in_run && !out_valid) begin
            gap++;
         end
         if (out_valid) begin
            in_run = 0;
            if (hold_pending) check("rd_hold", rd_addr, held);
            if (out_ready) begin
               hold_pending = 0;
               check("rd_expected", rd_exp.size() != 0, 1);
               if (rd_exp.size() != 0) check("rd_addr", rd_addr, rd_exp.pop_front());
               if (rd_addr == 6'd63) exp_done = 1;
            end else begin
               hold_pending = 1;
               held         = rd_addr;
            end
         end
      end
   end

   initial begin
      int cyc;
      tbl[0] = '{0,  0, {6'd0,  6'd1,  5'd0}};
      tbl[1] = '{1,  3, {6'd5,  6'd7,  5'd16}};
      tbl[2] = '{5, 31, {6'd31, 6'd63, 5'd31}};
      tbl[3] = '{2,  5, {6'd9,  6'd13, 5'd8}};
      tbl[4] = '{3, 13, {6'd21, 6'd29, 5'd20}};
      tbl[5] = '{4, 20, {6'd36, 6'd52, 5'd8}};
      tbl[6] = '{0, 17, {6'd34, 6'd35, 5'd0}};

      rst       = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", all_outs(), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Clean run straight out of reset: start on first edge, no stalls.
      run_transform(-1, 0, cyc);
      check("start_to_done", cyc, TOTAL_CYC);
      for (int i = 0; i < 7; i++)
         check($sformatf("addr_s%0d_k%0d", tbl[i].stg, tbl[i].k),
               issued[tbl[i].stg * 32 + tbl[i].k], tbl[i].exp);

      // Load stall, random unload backpressure, and a stray start during RUN.
      rand_ready = 1;
      run_transform(10, 1, cyc);
      rand_ready = 0;

      // Asynchronous reset in the middle of stage 3.
      push_expectations();
      start    = 1'b1;
      in_valid = 1'b1;
      cyc      = 0;
      tick();
      start = 1'b0;
      while (!(bf_en && stage == 3'd3)) begin
         tick();
         cyc++;
         if (cyc > 2000) begin
            check("reach_stage3_timeout", bf_en, 1);
            break;
         end
      end
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_outputs", all_outs(), 0);
      in_valid = 1'b0;
      tick();
      tick();
      ld_exp.delete();
      bf_exp.delete();
      rd_exp.delete();
      rst = 1'b1;
      run_transform(-1, 0, cyc);
      check("start_to_done_after_reset", cyc, TOTAL_CYC);

      tick();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
